// File: rtl/seq_csa_multiplier_if.sv
// Operand/result handshake bundle for seq_csa_multiplier.
// The master side issues operands and consumes results; the slave side is the multiplier.
interface seq_csa_multiplier_if #(
    parameter int A_WIDTH = 64,
    parameter int B_WIDTH = 64
);
    logic                       start;
    logic                       signed_mode;
    logic [A_WIDTH-1:0]         in_a;
    logic [B_WIDTH-1:0]         in_b;
    logic                       in_ready;
    logic                       busy;
    logic                       out_valid;
    logic                       out_ready;
    logic [A_WIDTH+B_WIDTH-1:0] product;

    modport master (
        output start, signed_mode, in_a, in_b, out_ready,
        input  in_ready, busy, out_valid, product
    );

    modport slave (
        input  start, signed_mode, in_a, in_b, out_ready,
        output in_ready, busy, out_valid, product
    );
endinterface

// File: rtl/seq_csa_multiplier.sv
// Sequential slice-by-slice multiplier with a carry-save accumulator.
// Operand A is walked MSB slice first; each slice times B is folded into a
// redundant sum/carry pair, and a single carry-propagate add resolves it.
module seq_csa_multiplier #(
    parameter int A_WIDTH     = 64,
    parameter int B_WIDTH     = 64,
    parameter int SLICE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_csa_multiplier_if.slave   bus
);
    localparam int NUM_SLICES = A_WIDTH / SLICE_WIDTH;
    localparam int P_WIDTH    = A_WIDTH + B_WIDTH;
    localparam int IDX_WIDTH  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    // Signed (SLICE_WIDTH+1) x (B_WIDTH+1) product always fits in this width.
    localparam int PP_WIDTH   = SLICE_WIDTH + B_WIDTH + 2;
    localparam int EXT_WIDTH  = (P_WIDTH > PP_WIDTH) ? P_WIDTH : PP_WIDTH;
    localparam logic [IDX_WIDTH-1:0] TOP_IDX = IDX_WIDTH'(NUM_SLICES - 1);

    if ((NUM_SLICES < 1) || (A_WIDTH % SLICE_WIDTH != 0)) begin : g_bad_params
        $error("seq_csa_multiplier: A_WIDTH must be a non-zero multiple of SLICE_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [A_WIDTH-1:0]   a_q, a_d;
    logic [B_WIDTH-1:0]   b_q, b_d;
    logic                 signed_q, signed_d;
    logic [P_WIDTH-1:0]   sum_q, sum_d;
    logic [P_WIDTH-1:0]   carry_q, carry_d;
    logic [P_WIDTH-1:0]   product_q, product_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 out_valid_q, out_valid_d;

    logic [SLICE_WIDTH-1:0]       slice;
    logic                         slice_signed;
    logic [SLICE_WIDTH:0]         slice_ext;
    logic [B_WIDTH:0]             b_ext;
    logic signed [PP_WIDTH-1:0]   pp_narrow;
    logic signed [EXT_WIDTH-1:0]  pp_wide;
    logic [P_WIDTH-1:0]           pp;
    logic [P_WIDTH-1:0]           csa_x, csa_y, csa_sum, csa_carry;
    logic                         in_ready;
    logic                         accept;

    // Select the A slice addressed by the down-counter.
    always_comb begin
        slice = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (idx_q == IDX_WIDTH'(i)) begin
                slice = a_q[i*SLICE_WIDTH +: SLICE_WIDTH];
            end
        end
    end

    // Partial product: only the top slice carries A's sign; B is signed in signed mode.
    always_comb begin
        slice_signed = signed_q && (idx_q == TOP_IDX);
        slice_ext    = {slice_signed & slice[SLICE_WIDTH-1], slice};
        b_ext        = {signed_q & b_q[B_WIDTH-1], b_q};
        pp_narrow    = PP_WIDTH'($signed(slice_ext)) * PP_WIDTH'($signed(b_ext));
        pp_wide      = EXT_WIDTH'(pp_narrow);
        pp           = pp_wide[P_WIDTH-1:0];
    end

    // 3:2 compression of the shifted accumulator pair with the new partial product.
    always_comb begin
        csa_x     = sum_q << SLICE_WIDTH;
        csa_y     = carry_q << SLICE_WIDTH;
        csa_sum   = csa_x ^ csa_y ^ pp;
        csa_carry = ((csa_x & csa_y) | (csa_x & pp) | (csa_y & pp)) << 1;
    end

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept   = bus.start && in_ready;

    // Next-state and datapath update; a DONE with out_ready can accept straight into RUN.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        signed_d    = signed_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        product_d   = product_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: ;
            RUN: begin
                sum_d   = csa_sum;
                carry_d = csa_carry;
                if (idx_q == '0) begin
                    state_d = RESOLVE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            RESOLVE: begin
                product_d   = sum_q + carry_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d      = bus.in_a;
            b_d      = bus.in_b;
            signed_d = bus.signed_mode;
            sum_d    = '0;
            carry_d  = '0;
            idx_d    = TOP_IDX;
            state_d  = RUN;
        end
    end

    // State registers with synchronous reset that discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            sum_q       <= '0;
            carry_q     <= '0;
            product_q   <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            signed_q    <= signed_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            product_q   <= product_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = (state_q == RUN) || (state_q == RESOLVE);
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
endmodule

// File: tb/tb_seq_csa_multiplier.sv
// Directed bench for seq_csa_multiplier: default 16-bit slicing plus 8/32/64-bit
// slice variants driven in parallel with the same operands.
module tb_seq_csa_multiplier;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signedMode;
    logic [63:0] inA;
    logic [63:0] inB;
    logic        outReady;

    int checks = 0;
    int errors = 0;

    int sliceWidths [4] = '{16, 8, 32, 64};
    int expLat      [4] = '{5, 9, 3, 2};

    seq_csa_multiplier_if #(.A_WIDTH(64), .B_WIDTH(64)) bus16 ();
    seq_csa_multiplier_if #(.A_WIDTH(64), .B_WIDTH(64)) bus8 ();
    seq_csa_multiplier_if #(.A_WIDTH(64), .B_WIDTH(64)) bus32 ();
    seq_csa_multiplier_if #(.A_WIDTH(64), .B_WIDTH(64)) bus64 ();

    assign bus16.start = start; assign bus16.signed_mode = signedMode;
    assign bus16.in_a = inA;    assign bus16.in_b = inB; assign bus16.out_ready = outReady;
    assign bus8.start = start;  assign bus8.signed_mode = signedMode;
    assign bus8.in_a = inA;     assign bus8.in_b = inB;  assign bus8.out_ready = outReady;
    assign bus32.start = start; assign bus32.signed_mode = signedMode;
    assign bus32.in_a = inA;    assign bus32.in_b = inB; assign bus32.out_ready = outReady;
    assign bus64.start = start; assign bus64.signed_mode = signedMode;
    assign bus64.in_a = inA;    assign bus64.in_b = inB; assign bus64.out_ready = outReady;

    seq_csa_multiplier #(.A_WIDTH(64), .B_WIDTH(64), .SLICE_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16.slave));
    seq_csa_multiplier #(.A_WIDTH(64), .B_WIDTH(64), .SLICE_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave));
    seq_csa_multiplier #(.A_WIDTH(64), .B_WIDTH(64), .SLICE_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .bus(bus32.slave));
    seq_csa_multiplier #(.A_WIDTH(64), .B_WIDTH(64), .SLICE_WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .bus(bus64.slave));

    logic [3:0]   validVec;
    logic [127:0] prodVec [4];
    assign validVec   = {bus64.out_valid, bus32.out_valid, bus8.out_valid, bus16.out_valid};
    assign prodVec[0] = bus16.product;
    assign prodVec[1] = bus8.product;
    assign prodVec[2] = bus32.product;
    assign prodVec[3] = bus64.product;

    always #5 clk = ~clk;

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic sm, input logic [63:0] a,
                                 input logic [63:0] b, input logic ordy);
        start      = s;
        signedMode = sm;
        inA        = a;
        inB        = b;
        outReady   = ordy;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for the default instance's out_valid; lat = edges after the next edge.
    task automatic waitValid16(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus16.out_valid) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    // One multiply on every slice variant with an always-ready consumer.
    task automatic runAll(input string tag, input logic sm, input logic [63:0] a,
                          input logic [63:0] b, input logic [127:0] expected);
        int           lat [4];
        logic [127:0] res [4];
        int           busyCnt;
        busyCnt = 0;
        for (int i = 0; i < 4; i++) begin
            lat[i] = -1;
            res[i] = '0;
        end
        @(negedge clk);
        applyStimulus(1'b1, sm, a, b, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (lat[0] < 0 && !validVec[0] && bus16.busy) busyCnt++;
            for (int i = 0; i < 4; i++) begin
                if (lat[i] < 0 && validVec[i]) begin
                    lat[i] = k - 1;
                    res[i] = prodVec[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s lat sw%0d", tag, sliceWidths[i]), 128'(lat[i]), 128'(expLat[i]));
            checkOutput($sformatf("%s product sw%0d", tag, sliceWidths[i]), res[i], expected);
        end
        checkOutput($sformatf("%s busy cycles", tag), 128'(busyCnt), 128'd5);
    endtask

    initial begin
        int lat;
        int stable;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset inReady", 128'(bus16.in_ready), 128'd1);
        checkOutput("reset busy", 128'(bus16.busy), 128'd0);
        checkOutput("reset outValid", 128'(bus16.out_valid), 128'd0);
        checkOutput("reset product", bus16.product, 128'd0);
        rst = 1'b0;

        runAll("u3x5", 1'b0, 64'd3, 64'd5, 128'd15);
        runAll("umax", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        runAll("u0xmax", 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 128'd0);
        runAll("uShift", 1'b0, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE,
               128'h0000_0000_FFFF_FFFF_FFFF_FFFE_0000_0000);
        runAll("uMaxPos", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
               128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);
        runAll("sM1xM1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1);
        runAll("sMinx1", 1'b1, 64'h8000_0000_0000_0000, 64'd1,
               128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000);
        runAll("sMinxMin", 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               128'h4000_0000_0000_0000_0000_0000_0000_0000);
        runAll("sM7x3", 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB);
        runAll("sPosxNeg", 1'b1, 64'h0000_0000_0001_0003, 64'hFFFF_FFFF_FFFF_FFFB,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA_FFF1);
        runAll("sShift", 1'b1, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFE_0000_0000);
        runAll("sMaxPos", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
               128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);

        // Consumer stalls: result must hold, and a start in DONE must be ignored.
        doReset();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 64'h1234_5678, 64'h10, 1'b0);
        waitValid16(20, lat);
        checkOutput("hold lat", 128'(lat), 128'd5);
        stable = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                checkOutput("hold inReady", 128'(bus16.in_ready), 128'd0);
                applyStimulus(1'b1, 1'b1, 64'd9, 64'd9, 1'b0);
            end
            @(negedge clk);
            start = 1'b0;
            if (bus16.out_valid && bus16.product == 128'h1_2345_6780) stable++;
        end
        checkOutput("hold stable cycles", 128'(stable), 128'd10);
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("release outValid", 128'(bus16.out_valid), 128'd0);
        checkOutput("release busy", 128'(bus16.busy), 128'd0);
        checkOutput("release product held", bus16.product, 128'h1_2345_6780);

        // A start while RUN must not disturb the operation in flight.
        doReset();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 64'd3, 64'd5, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 64'd6, 64'd7, 1'b1);
        waitValid16(20, lat);
        checkOutput("runStart lat", 128'(lat), 128'd3);
        checkOutput("runStart product", bus16.product, 128'd15);
        @(negedge clk);
        checkOutput("runStart idle busy", 128'(bus16.busy), 128'd0);
        checkOutput("runStart idle outValid", 128'(bus16.out_valid), 128'd0);

        // Back-to-back: start together with out_ready in DONE.
        doReset();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 64'd3, 64'd5, 1'b1);
        waitValid16(20, lat);
        checkOutput("b2b first lat", 128'(lat), 128'd5);
        checkOutput("b2b first product", bus16.product, 128'd15);
        checkOutput("b2b inReady in DONE", 128'(bus16.in_ready), 128'd1);
        applyStimulus(1'b1, 1'b0, 64'd6, 64'd7, 1'b1);
        waitValid16(20, lat);
        checkOutput("b2b second lat", 128'(lat), 128'd5);
        checkOutput("b2b second product", bus16.product, 128'd42);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 64'd1000, 64'd1000, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("midReset busy before", 128'(bus16.busy), 128'd1);
        checkOutput("midReset product before", bus16.product, 128'd42);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midReset busy", 128'(bus16.busy), 128'd0);
        checkOutput("midReset outValid", 128'(bus16.out_valid), 128'd0);
        checkOutput("midReset product", bus16.product, 128'd0);
        checkOutput("midReset inReady", 128'(bus16.in_ready), 128'd1);
        rst = 1'b0;
        runAll("afterReset", 1'b0, 64'd6, 64'd7, 128'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_csa_multiplier.md
# seq_csa_multiplier

Parametrised sequential multiplier: operand A is split into `NUM_SLICES = A_WIDTH/SLICE_WIDTH` slices, consumed MSB-first, one per cycle. Each slice's partial products against B go into a carry-save accumulator. A single carry-propagate add resolves the result. Supersedes the fixed 64x64, two-pass, free-running multiplier with a start/valid/ready handshake, configurable slice count and a signed mode. It sits between the operand staging registers and the result FIFO of the arithmetic datapath.

## Interface
- `A_WIDTH`, default 64, width of operand A; must be a multiple of `SLICE_WIDTH`.
- `B_WIDTH`, default 64, width of operand B.
- `SLICE_WIDTH`, default 16, A bits consumed per cycle; `NUM_SLICES = A_WIDTH/SLICE_WIDTH`, ≥ 1.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request to begin a multiply with current `in_a`/`in_b`/`signed_mode`.
- `signed_mode`  in  1  1 = both operands two's complement; 0 = unsigned.
- `in_a`  in  `A_WIDTH`  multiplicand.
- `in_b`  in  `B_WIDTH`  multiplier.
- `in_ready`  out  1  start will be accepted this cycle.
- `busy`  out  1  state is RUN or RESOLVE.
- `out_valid`  out  1  `product` holds a finished result.
- `out_ready`  in  1  consumer accepts `product`.
- `product`  out  `A_WIDTH+B_WIDTH`  result.

## Operation
- States:
  - IDLE: wait for start.
  - RUN: `NUM_SLICES` cycles, down-counter `idx` from `NUM_SLICES-1` to 0.
  - RESOLVE: 1 cycle.
  - DONE: hold the result.
- Accept (`start & in_ready`):
  - latch `in_a`, `in_b`, `signed_mode`;
  - clear sum/carry registers to 0;
  - set `idx = NUM_SLICES-1`;
  - go to RUN.
- `in_ready = (state==IDLE) | (state==DONE & out_ready)`. A start in RUN/RESOLVE, or in DONE without `out_ready`, is ignored with no side effect.
- Partial product `pp = slice(A, idx) * B`, sign-extended or zero-extended to `A_WIDTH+B_WIDTH`:
  - B is signed when `signed_mode`=1;
  - the A slice is signed only when `signed_mode`=1 and `idx == NUM_SLICES-1` (top slice); all lower slices are unsigned.
- RUN step (3:2 compressor, bitwise): `{sum, carry} = CSA(sum << SLICE_WIDTH, carry << SLICE_WIDTH, pp)`. The carry output is shifted left by 1. All arithmetic is modulo 2^(A_WIDTH+B_WIDTH); bits shifted out are discarded.
- `idx` reaching 0 moves the state to RESOLVE.
- RESOLVE: `product <= sum + carry` (modulo 2^(A_WIDTH+B_WIDTH)), `out_valid <= 1`, go to DONE.
- DONE: `product` and `out_valid` stay stable until `out_ready`=1 at an edge.
  - Without a simultaneous start: clear `out_valid`, go to IDLE.
  - With a simultaneous start: clear `out_valid` and accept the new operands into RUN (back-to-back).
- `product` holds its last value after `out_valid` falls.
- Reset, at any time including mid-RUN: state IDLE, `out_valid`=0, `busy`=0, `in_ready`=1, `product`=0, sum/carry/idx=0. Any in-flight operation is discarded with no output.

## Timing
- Accept edge = E. RUN occupies edges E+1..E+NUM_SLICES. RESOLVE result registers at edge E+NUM_SLICES+1, and `out_valid` is high after that edge.
- Latency is therefore NUM_SLICES+1 cycles (5 at defaults). Throughput is one result per NUM_SLICES+2 cycles with a consumer that is always ready.
- `busy` is high from E+1 through the RESOLVE edge, and low in IDLE and DONE.
- All outputs are registered or decoded from the state register only; no combinational path from `in_a`/`in_b` to outputs. `in_ready` depends combinationally on `out_ready`.
- `NUM_SLICES`=1 is legal: one RUN cycle, latency 2.

## Test plan
- Unsigned basic, defaults: `in_a`=3, `in_b`=5, `signed_mode`=0, start pulse, `out_ready`=1 → `out_valid` exactly 5 cycles after accept, `product`=15, `busy` high for 5 cycles (4 RUN + RESOLVE).
- Unsigned extremes: `in_a`=`in_b`=0xFFFF_FFFF_FFFF_FFFF → `product`=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001; also A=0 × B=max → 0.
- Signed corners (`signed_mode`=1):
  - −1 × −1 → 1;
  - 0x8000_0000_0000_0000 × 1 → 0xFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000;
  - 0x8000_0000_0000_0000 × 0x8000_0000_0000_0000 → 0x4000_0000_0000_0000_0000_0000_0000_0000;
  - −7 × 3 → −21 sign-extended to 128 bits.
- Handshake:
  - hold `out_ready`=0 for 10 cycles → `product` stable, `out_valid` stays high;
  - a start during RUN with different operands is ignored, so the first result is unchanged;
  - `start`+`out_ready` together in DONE → second result 5 cycles later, no idle gap.
- Reset mid-operation: assert `rst` at RUN cycle 2 → next cycle state IDLE, `out_valid`=0, `product`=0. A subsequent 6×7 returns 42.
- Parameter sweep: `SLICE_WIDTH` ∈ {8, 32, 64} with random signed/unsigned operands compared against a reference product; latency = NUM_SLICES+1 each.
